// File: rtl/xoro_bus_pkg.sv
// Shared definitions for the xoro native valid/ready memory bus.
// Arbiter state encoding, default bus widths and the timeout read-data pattern.
package xoro_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter onto one slave port, with per-transaction timeout and sticky error.
// Latency: 1 arbitration cycle, then the slave's own latency; ready/rdata are combinational from s_ready.
// Backpressure: a granted master waits on s_ready (bounded by TIMEOUT); the other master stalls until IDLE.
module mem_bus_arbiter
    import xoro_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TIMEOUT = 255,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(TIMEOUT_DATA_DEF)
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                m0_valid,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_ready,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_valid,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_ready,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic                s_valid,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_ready,
    input  logic [DATA_W-1:0]   s_rdata,

    output logic                busy,
    output logic                timeout_err,
    input  logic                err_clr
);

    // A zero-width timer is illegal, so TIMEOUT=0 keeps a 1-bit timer that never counts.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT > 0);
    localparam logic [TW-1:0] TO_LIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t      state;
    logic            last_grant;
    logic [TW-1:0]   timer;

    logic            sel0;
    logic            sel1;
    logic            gnt_valid;
    logic            done;
    logic            expire;
    logic [DATA_W-1:0] rsp_dat;

    assign sel0      = (state == GNT0);
    assign sel1      = (state == GNT1);
    assign gnt_valid = (sel0 & m0_valid) | (sel1 & m1_valid);

    assign s_valid = gnt_valid;
    assign s_addr  = sel0 ? m0_addr  : (sel1 ? m1_addr  : '0);
    assign s_wdata = sel0 ? m0_wdata : (sel1 ? m1_wdata : '0);
    assign s_wstrb = sel0 ? m0_wstrb : (sel1 ? m1_wstrb : '0);

    // s_ready in the expiry cycle is a normal completion, hence the !s_ready term.
    assign done    = gnt_valid & s_ready;
    assign expire  = TO_EN && gnt_valid && !s_ready && (timer == TO_LIM);
    assign rsp_dat = done ? s_rdata : TIMEOUT_DATA;

    assign m0_ready = sel0 & (done | expire);
    assign m1_ready = sel1 & (done | expire);
    assign m0_rdata = m0_ready ? rsp_dat : '0;
    assign m1_rdata = m1_ready ? rsp_dat : '0;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            timer       <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (expire) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    timer <= '0;
                    if (m0_valid && (!m1_valid || last_grant)) begin
                        state      <= GNT0;
                        last_grant <= 1'b0;
                    end else if (m1_valid) begin
                        state      <= GNT1;
                        last_grant <= 1'b1;
                    end
                end
                GNT0, GNT1: begin
                    // A dropped request abandons the grant silently.
                    if (!gnt_valid || done || expire) begin
                        state <= IDLE;
                    end else if (TO_EN) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
